// File: rtl/fir_out_decim_fifo.sv
// Decimating output stage for the 8-tap FIR: keeps every DECIM-th valid sample,
// buffers kept samples in a show-ahead FIFO with valid/ready egress and a sticky overflow flag.
module fir_out_decim_fifo #(
  parameter int NB    = 13,
  parameter int DECIM = 2,
  parameter int DEPTH = 8
) (
  input  logic                   CLK,
  input  logic                   RST_n,
  input  logic signed [NB-1:0]   DIN,
  input  logic                   VIN,
  input  logic                   RDY,
  input  logic                   OVF_CLR,
  output logic signed [NB-1:0]   DOUT,
  output logic                   VOUT,
  output logic [$clog2(DEPTH):0] LEVEL,
  output logic                   OVF
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [PW-1:0] PH_LAST  = PW'(DECIM - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  logic signed [NB-1:0] mem_q [DEPTH];
  logic [PW-1:0]        phase_q, phase_d;
  logic [AW-1:0]        wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0]        level_q, level_d;
  logic                 vout_q, vout_d;
  logic                 ovf_q, ovf_d;
  logic signed [NB-1:0] dout_q, dout_d;
  logic                 keep, push, pop, drop, full;

  always_comb begin
    keep = VIN && (phase_q == '0);
    pop  = vout_q && RDY;
    full = (level_q == LVL_FULL);
    // A full FIFO still accepts a kept sample when the head leaves in the same cycle.
    push = keep && (!full || pop);
    drop = keep && full && !pop;

    phase_d = phase_q;
    if (VIN) phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;

    wr_d = push ? wr_q + 1'b1 : wr_q;
    rd_d = pop  ? rd_q + 1'b1 : rd_q;

    level_d = level_q;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (pop && !push) level_d = level_q - 1'b1;

    vout_d = (level_d != '0);

    // Show-ahead head register; bypass DIN when the new head is being written this cycle.
    dout_d = dout_q;
    if (level_d != '0) dout_d = (push && (wr_q == rd_d)) ? DIN : mem_q[rd_d];

    ovf_d = drop | (ovf_q & ~OVF_CLR);
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      phase_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      vout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      phase_q <= phase_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      vout_q  <= vout_d;
      ovf_q   <= ovf_d;
      dout_q  <= dout_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST_n && push) mem_q[wr_q] <= DIN;
  end

  assign DOUT  = dout_q;
  assign VOUT  = vout_q;
  assign LEVEL = level_q;
  assign OVF   = ovf_q;
endmodule

// File: tb/tb_fir_out_decim_fifo.sv
// Bench for fir_out_decim_fifo: a DECIM=2 and a DECIM=1 instance share stimulus and are
// checked against fixed vectors, hand sequences and a queue-based reference model.
module tb_fir_out_decim_fifo;
  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic signed [12:0] din = '0;
  logic               vin = 1'b0;
  logic               rdy = 1'b0;
  logic               ovf_clr = 1'b0;
  logic signed [12:0] dout0, dout1;
  logic               vout0, vout1, ovf0, ovf1;
  logic [3:0]         lvl0, lvl1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fir_out_decim_fifo #(.NB(13), .DECIM(2), .DEPTH(8)) dut0 (
    .CLK(clk), .RST_n(rst_n), .DIN(din), .VIN(vin), .RDY(rdy), .OVF_CLR(ovf_clr),
    .DOUT(dout0), .VOUT(vout0), .LEVEL(lvl0), .OVF(ovf0));

  fir_out_decim_fifo #(.NB(13), .DECIM(1), .DEPTH(8)) dut1 (
    .CLK(clk), .RST_n(rst_n), .DIN(din), .VIN(vin), .RDY(rdy), .OVF_CLR(ovf_clr),
    .DOUT(dout1), .VOUT(vout1), .LEVEL(lvl1), .OVF(ovf1));

  // Reference model: a sample queue per instance plus phase, overflow and head value.
  int q0[$];
  int q1[$];
  int ph[2];
  bit movf[2];
  int mdout[2];
  bit chk_model = 1'b0;

  task automatic model_step(input int k);
    int  q[$];
    int  dec;
    bit  pop, keep, drop;
    dec = (k == 0) ? 2 : 1;
    if (k == 0) q = q0; else q = q1;
    if (!rst_n) begin
      q.delete();
      ph[k] = 0;
      movf[k] = 1'b0;
      mdout[k] = 0;
    end else begin
      pop  = (q.size() > 0) && rdy;
      keep = vin && (ph[k] == 0);
      if (vin) ph[k] = (ph[k] + 1) % dec;
      if (pop) void'(q.pop_front());
      drop = 1'b0;
      if (keep) begin
        if (q.size() < 8) q.push_back(int'(din));
        else drop = 1'b1;
      end
      if (drop) movf[k] = 1'b1;
      else if (ovf_clr) movf[k] = 1'b0;
      if (q.size() > 0) mdout[k] = q[0];
    end
    if (k == 0) q0 = q; else q1 = q;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    if (chk_model) begin
      chk("m0_vout",  int'(vout0), (q0.size() > 0) ? 1 : 0);
      chk("m0_level", int'(lvl0),  q0.size());
      chk("m0_dout",  int'(dout0), mdout[0]);
      chk("m0_ovf",   int'(ovf0),  int'(movf[0]));
      chk("m1_vout",  int'(vout1), (q1.size() > 0) ? 1 : 0);
      chk("m1_level", int'(lvl1),  q1.size());
      chk("m1_dout",  int'(dout1), mdout[1]);
      chk("m1_ovf",   int'(ovf1),  int'(movf[1]));
    end
  endtask

  typedef struct {
    bit rst_n;
    bit vin;
    bit rdy;
    bit clr;
    int din;
    bit e_vout;
    int e_dout;
    int e_lvl;
    bit e_ovf;
  } vec_t;

  vec_t tv[15];

  initial begin
    // reset with VIN high, then decimation 1..6, then gapped input
    tv[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 77, 1'b0, 0, 0, 1'b0};
    tv[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 78, 1'b0, 0, 0, 1'b0};
    tv[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 79, 1'b0, 0, 0, 1'b0};
    tv[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1,  1'b1, 1, 1, 1'b0};
    tv[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2,  1'b0, 1, 0, 1'b0};
    tv[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3,  1'b1, 3, 1, 1'b0};
    tv[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4,  1'b0, 3, 0, 1'b0};
    tv[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 5,  1'b1, 5, 1, 1'b0};
    tv[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 6,  1'b0, 5, 0, 1'b0};
    tv[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 10, 1'b1, 10, 1, 1'b0};
    tv[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 99, 1'b0, 10, 0, 1'b0};
    tv[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 98, 1'b0, 10, 0, 1'b0};
    tv[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 20, 1'b0, 10, 0, 1'b0};
    tv[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 30, 1'b1, 30, 1, 1'b0};
    tv[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 0,  1'b0, 30, 0, 1'b0};

    #1;
    for (int i = 0; i < 15; i++) begin
      rst_n   = tv[i].rst_n;
      vin     = tv[i].vin;
      rdy     = tv[i].rdy;
      ovf_clr = tv[i].clr;
      din     = 13'(tv[i].din);
      cycle();
      chk($sformatf("tv%0d_vout", i),  int'(vout0), int'(tv[i].e_vout));
      chk($sformatf("tv%0d_dout", i),  int'(dout0), tv[i].e_dout);
      chk($sformatf("tv%0d_level", i), int'(lvl0),  tv[i].e_lvl);
      chk($sformatf("tv%0d_ovf", i),   int'(ovf0),  int'(tv[i].e_ovf));
    end

    // Full/overflow on the DECIM=1 instance
    rst_n = 1'b0; vin = 1'b0; rdy = 1'b0; ovf_clr = 1'b0;
    cycle();
    rst_n = 1'b1; vin = 1'b1;
    for (int i = 0; i < 9; i++) begin
      din = 13'(-4096 + i);
      cycle();
      if (i == 7) chk("full_ovf_before_drop", int'(ovf1), 0);
    end
    chk("full_level", int'(lvl1), 8);
    chk("full_ovf", int'(ovf1), 1);
    chk("full_head", int'(dout1), -4096);
    vin = 1'b0; rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d_vout", i), int'(vout1), 1);
      chk($sformatf("drain%0d_dout", i), int'(dout1), -4096 + i);
      cycle();
    end
    chk("drained_vout", int'(vout1), 0);
    chk("drained_level", int'(lvl1), 0);
    chk("drained_dout_hold", int'(dout1), -4089);

    // OVF_CLR without a drop, then with a drop in the same cycle
    rdy = 1'b0; ovf_clr = 1'b1;
    cycle();
    chk("clr_no_drop", int'(ovf1), 0);
    ovf_clr = 1'b0; vin = 1'b1;
    for (int i = 0; i < 8; i++) begin
      din = 13'(100 + i);
      cycle();
    end
    chk("refill_level", int'(lvl1), 8);
    din = 13'(555); ovf_clr = 1'b1;
    cycle();
    chk("clr_with_drop", int'(ovf1), 1);
    chk("clr_with_drop_level", int'(lvl1), 8);

    // Full FIFO with simultaneous pop and push
    vin = 1'b0; ovf_clr = 1'b1;
    cycle();
    chk("clr_again", int'(ovf1), 0);
    ovf_clr = 1'b0; vin = 1'b1; rdy = 1'b1; din = 13'(4095);
    cycle();
    chk("pp_level", int'(lvl1), 8);
    chk("pp_ovf", int'(ovf1), 0);
    vin = 1'b0;
    for (int i = 1; i < 8; i++) begin
      chk($sformatf("pp_head%0d", i), int'(dout1), 100 + i);
      cycle();
    end
    chk("pp_last_dout", int'(dout1), 4095);
    chk("pp_last_vout", int'(vout1), 1);
    cycle();
    chk("pp_empty", int'(vout1), 0);

    // Reset mid-stream with five entries stored
    rdy = 1'b0; vin = 1'b1;
    for (int i = 0; i < 5; i++) begin
      din = 13'(-7 - i);
      cycle();
    end
    chk("mid_level", int'(lvl1), 5);
    rst_n = 1'b0; vin = 1'b1;
    cycle();
    chk("mid_rst_level", int'(lvl1), 0);
    chk("mid_rst_vout", int'(vout1), 0);
    chk("mid_rst_dout", int'(dout1), 0);
    chk("mid_rst_ovf", int'(ovf1), 0);

    // Randomized traffic against the model
    rst_n = 1'b1; vin = 1'b0;
    cycle();
    chk_model = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      rst_n   = ($urandom_range(0, 199) != 0);
      vin     = ($urandom_range(0, 9) < 7);
      rdy     = (i < 1500) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 6);
      ovf_clr = ($urandom_range(0, 19) == 0);
      din     = 13'($urandom);
      cycle();
    end
    chk_model = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
